// File: rtl/regfile_write_arbiter_pkg.sv
// Register-file geometry shared by the write arbiter, its interface and sub-blocks.
// Provides the one-hot decode used to flag the register currently being written.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO_ADDR = 5'd0;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [REG_COUNT-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle plus the registered register-file write port.
// The slave side is the arbiter; the master side is the requesters/regfile/tb.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);

  logic                     Hold;
  logic [NREQ-1:0]          ReqValid;
  logic [NREQ-1:0]          ReqReady;
  logic [NREQ*ADDR_W-1:0]   ReqAddr;
  logic [NREQ*DATA_W-1:0]   ReqData;
  logic                     RegWrite;
  logic [ADDR_W-1:0]        WriteRegister;
  logic [DATA_W-1:0]        WriteData;
  logic [REG_COUNT-1:0]     PendingMask;

  modport slave (
    input  Hold, ReqValid, ReqAddr, ReqData,
    output ReqReady, RegWrite, WriteRegister, WriteData, PendingMask
  );

  modport master (
    output Hold, ReqValid, ReqAddr, ReqData,
    input  ReqReady, RegWrite, WriteRegister, WriteData, PendingMask
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin one-hot grant over NREQ requesters, zero latency; hold or reset
// forces all grants low. Pointer moves to winner+1 only when advance is set.
module regfile_write_arbiter_rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             hold,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               scan;

  // Scan ptr, ptr+1, ... mod NREQ; the first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = 0;
    if (rst_n && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        scan = int'(ptr) + k;
        if (scan >= NREQ) scan = scan - NREQ;
        if (!found && req[scan]) begin
          found       = 1'b1;
          grant[scan] = 1'b1;
          grant_idx   = IDX_W'(scan);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port among NREQ writeback sources, one write per cycle;
// handshake at edge N commits at edge N+1. Losers simply keep valid until granted.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  regfile_write_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              handshake;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  regfile_write_arbiter_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk       (Clk),
    .rst_n     (ResetN),
    .req       (bus.ReqValid),
    .hold      (bus.Hold),
    .advance   (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign handshake = |(grant & bus.ReqValid);
  assign win_addr  = bus.ReqAddr[grant_idx*ADDR_W +: ADDR_W];
  assign win_data  = bus.ReqData[grant_idx*DATA_W +: DATA_W];

  // r0 writes are consumed but never reach the regfile write enable.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (handshake) begin
      wr_en_q   <= (win_addr != ADDR_W'(REG_ZERO_ADDR));
      wr_addr_q <= win_addr;
      wr_data_q <= win_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  assign bus.ReqReady      = grant;
  assign bus.RegWrite      = wr_en_q;
  assign bus.WriteRegister = wr_addr_q;
  assign bus.WriteData     = wr_data_q;
  assign bus.PendingMask   = wr_en_q ? reg_onehot(REG_ADDR_W'(wr_addr_q)) : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=2) with a scoreboard of expected
// write-port values and a behavioural register file fed from the write port.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } out_t;

  logic Clk;
  logic ResetN;
  logic rf_clr;
  logic [31:0] rf [32];

  out_t        exp_q[$];
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  int          checks;
  int          errors;

  regfile_write_arbiter_if #(.NREQ(2)) bus ();

  regfile_write_arbiter #(.NREQ(2)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (bus.RegWrite) begin
      rf[bus.WriteRegister] <= bus.WriteData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, check the grant, push the expected write port value,
  // then pop and compare it after the edge.
  task automatic step(input string tag, input logic hold, input logic [1:0] valid,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic [1:0] exp_gnt);
    out_t e;
    @(negedge Clk);
    bus.Hold     = hold;
    bus.ReqValid = valid;
    bus.ReqAddr  = {a1, a0};
    bus.ReqData  = {d1, d0};
    #1;
    chk({tag, "_grant"}, {30'd0, bus.ReqReady}, {30'd0, exp_gnt});
    if (exp_gnt[0]) begin
      e = '{we: (a0 != 5'd0), addr: a0, data: d0};
      last_addr = a0; last_data = d0;
    end else if (exp_gnt[1]) begin
      e = '{we: (a1 != 5'd0), addr: a1, data: d1};
      last_addr = a1; last_data = d1;
    end else begin
      e = '{we: 1'b0, addr: last_addr, data: last_data};
    end
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_we"},   {31'd0, bus.RegWrite},      {31'd0, e.we});
    chk({tag, "_addr"}, {27'd0, bus.WriteRegister}, {27'd0, e.addr});
    chk({tag, "_data"}, bus.WriteData,              e.data);
    chk({tag, "_mask"}, bus.PendingMask,            e.we ? (32'd1 << e.addr) : 32'd0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00);
  endtask

  initial begin
    checks = 0; errors = 0;
    last_addr = '0; last_data = '0;
    rf_clr = 1'b1;
    ResetN = 1'b0;
    bus.Hold = 1'b0;
    bus.ReqValid = 2'b11;
    bus.ReqAddr = {5'd2, 5'd1};
    bus.ReqData = {32'h2222, 32'h1111};

    // Reset holds everything low, including grants with requests pending.
    #3;
    chk("rst_ready", {30'd0, bus.ReqReady}, 32'd0);
    chk("rst_we",    {31'd0, bus.RegWrite}, 32'd0);
    chk("rst_addr",  {27'd0, bus.WriteRegister}, 32'd0);
    chk("rst_data",  bus.WriteData, 32'd0);
    chk("rst_mask",  bus.PendingMask, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    bus.ReqValid = 2'b00;
    ResetN = 1'b1;
    rf_clr = 1'b0;

    // Single write
    step("single", 1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 2'b01);
    idle("single_idle");
    chk("rf_r5", rf[5], 32'hDEADBEEF);

    // r0 write is consumed but never committed
    step("zero", 1'b0, 2'b10, 5'd0, 32'd0, 5'd0, 32'h1, 2'b10);
    idle("zero_idle");
    chk("rf_r0", rf[0], 32'd0);

    // Contention alternates starting from index 0
    step("cont0", 1'b0, 2'b11, 5'd3, 32'hA0A0_0001, 5'd4, 32'hB0B0_0001, 2'b01);
    step("cont1", 1'b0, 2'b11, 5'd3, 32'hA0A0_0002, 5'd4, 32'hB0B0_0001, 2'b10);
    step("cont2", 1'b0, 2'b11, 5'd3, 32'hA0A0_0002, 5'd4, 32'hB0B0_0002, 2'b01);
    step("cont3", 1'b0, 2'b11, 5'd3, 32'hA0A0_0003, 5'd4, 32'hB0B0_0002, 2'b10);
    idle("cont_idle");
    chk("rf_r3", rf[3], 32'hA0A0_0002);
    chk("rf_r4", rf[4], 32'hB0B0_0002);

    // Move pointer to 1, then stall with both valid
    step("pre_hold", 1'b0, 2'b01, 5'd10, 32'h10, 5'd0, 32'd0, 2'b01);
    for (int i = 0; i < 3; i++)
      step("hold", 1'b1, 2'b11, 5'd11, 32'h11, 5'd12, 32'h12, 2'b00);
    step("release", 1'b0, 2'b11, 5'd11, 32'h11, 5'd12, 32'h12, 2'b10);
    step("release2", 1'b0, 2'b01, 5'd11, 32'h11, 5'd12, 32'h12, 2'b01);
    step("wrap", 1'b0, 2'b10, 5'd0, 32'd0, 5'd13, 32'h13, 2'b10);
    idle("wrap_idle");
    chk("rf_r10", rf[10], 32'h10);
    chk("rf_r11", rf[11], 32'h11);

    // Same destination from both requesters, pointer at 0
    step("same0", 1'b0, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 2'b01);
    step("same1", 1'b0, 2'b10, 5'd7, 32'h1, 5'd7, 32'h2, 2'b10);
    chk("rf_r7_first", rf[7], 32'h1);
    idle("same_idle");
    chk("rf_r7_second", rf[7], 32'h2);

    // Asynchronous reset while a write is in flight
    step("inflight", 1'b0, 2'b01, 5'd9, 32'h55, 5'd0, 32'd0, 2'b01);
    #2;
    ResetN = 1'b0;
    #1;
    chk("arst_ready", {30'd0, bus.ReqReady}, 32'd0);
    chk("arst_we",    {31'd0, bus.RegWrite}, 32'd0);
    chk("arst_addr",  {27'd0, bus.WriteRegister}, 32'd0);
    chk("arst_data",  bus.WriteData, 32'd0);
    chk("arst_mask",  bus.PendingMask, 32'd0);
    @(negedge Clk);
    bus.ReqValid = 2'b00;
    ResetN = 1'b1;
    last_addr = '0;
    last_data = '0;
    exp_q.delete();
    chk("rf_r9_dropped", rf[9], 32'd0);

    // Pointer restarts at 0 after reset
    step("post_rst", 1'b0, 2'b11, 5'd20, 32'h20, 5'd21, 32'h21, 2'b01);
    idle("post_idle");
    chk("rf_r20", rf[20], 32'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
